// File: rtl/lzx_74hc112_dual_jk.sv
// Dual JK flip-flop in the style of the 74HC112. Each channel's device clock is
// sampled on the system clock, and the JK action fires on a detected falling edge.
module lzx_74hc112_dual_jk (
  input  logic clk,
  input  logic rst,
  input  logic nSd1,
  input  logic nRd1,
  input  logic nClk1,
  input  logic J1,
  input  logic K1,
  output logic Q1,
  output logic nQ1,
  input  logic nSd2,
  input  logic nRd2,
  input  logic nClk2,
  input  logic J2,
  input  logic K2,
  output logic Q2,
  output logic nQ2
);

  logic [1:0] w_nsd, w_nrd, w_nclk, w_j, w_k, w_fall;
  logic [1:0] w_q_d, w_nq_d;
  logic [1:0] r_q, r_nq, r_p;

  assign w_nsd  = {nSd2, nSd1};
  assign w_nrd  = {nRd2, nRd1};
  assign w_nclk = {nClk2, nClk1};
  assign w_j    = {J2, J1};
  assign w_k    = {K2, K1};
  assign w_fall = r_p & ~w_nclk;

  // Set/clear take priority over the JK action; an edge that arrives with them is discarded.
  always_comb begin
    w_q_d  = r_q;
    w_nq_d = ~r_q;
    for (int i = 0; i < 2; i++) begin
      if (!w_nsd[i] && !w_nrd[i]) begin
        w_q_d[i]  = 1'b1;
        w_nq_d[i] = 1'b1;
      end else if (!w_nsd[i]) begin
        w_q_d[i]  = 1'b1;
        w_nq_d[i] = 1'b0;
      end else if (!w_nrd[i]) begin
        w_q_d[i]  = 1'b0;
        w_nq_d[i] = 1'b1;
      end else if (w_fall[i]) begin
        unique case ({w_j[i], w_k[i]})
          2'b01:   w_q_d[i] = 1'b0;
          2'b10:   w_q_d[i] = 1'b1;
          2'b11:   w_q_d[i] = ~r_q[i];
          default: w_q_d[i] = r_q[i];
        endcase
        w_nq_d[i] = ~w_q_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q  <= 2'b00;
      r_nq <= 2'b11;
      r_p  <= 2'b00;
    end else begin
      r_q  <= w_q_d;
      r_nq <= w_nq_d;
      r_p  <= w_nclk;
    end
  end

  assign Q1  = r_q[0];
  assign nQ1 = r_nq[0];
  assign Q2  = r_q[1];
  assign nQ2 = r_nq[1];

endmodule

// File: tb/tb_lzx_74hc112_dual_jk.sv
// Directed bench for the dual JK flip-flop; outputs are checked as {Q1,nQ1,Q2,nQ2}
// one time unit after each rising clk edge.
module tb_lzx_74hc112_dual_jk;

  logic clk = 1'b0;
  logic rst;
  logic nSd1, nRd1, nClk1, J1, K1, Q1, nQ1;
  logic nSd2, nRd2, nClk2, J2, K2, Q2, nQ2;

  int n_checks = 0;
  int n_errors = 0;
  logic q1_m;

  always #5 clk = ~clk;

  lzx_74hc112_dual_jk u_dut (
    .clk  (clk),
    .rst  (rst),
    .nSd1 (nSd1),
    .nRd1 (nRd1),
    .nClk1(nClk1),
    .J1   (J1),
    .K1   (K1),
    .Q1   (Q1),
    .nQ1  (nQ1),
    .nSd2 (nSd2),
    .nRd2 (nRd2),
    .nClk2(nClk2),
    .J2   (J2),
    .K2   (K2),
    .Q2   (Q2),
    .nQ2  (nQ2)
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got {Q1,nQ1,Q2,nQ2}=%b, expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] outs();
    return {Q1, nQ1, Q2, nQ2};
  endfunction

  initial begin
    rst = 1'b1;
    nSd1 = 1'b1; nRd1 = 1'b1; nClk1 = 1'b1; J1 = 1'b0; K1 = 1'b0;
    nSd2 = 1'b1; nRd2 = 1'b1; nClk2 = 1'b1; J2 = 1'b0; K2 = 1'b0;

    // 1. Reset, then idle toggling with J=K=0
    tick();
    tick();
    check("reset", outs(), 4'b0101);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      nClk1 = ~nClk1;
      nClk2 = ~nClk2;
      tick();
      check("hold_jk00", outs(), 4'b0101);
    end

    // 2. Set / clear pulses on channel 1
    nSd1 = 1'b0;
    tick();
    check("set1", outs(), 4'b1001);
    nSd1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("set1_held", outs(), 4'b1001);
    end
    nRd1 = 1'b0;
    tick();
    check("clr1", outs(), 4'b0101);
    nRd1 = 1'b1;
    tick();
    check("clr1_held", outs(), 4'b0101);

    // 3. Toggle channel 1 every nClk1 falling edge
    J1 = 1'b1; K1 = 1'b1;
    q1_m = 1'b0;
    for (int e = 0; e < 4; e++) begin
      nClk1 = 1'b0;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (c == 0) q1_m = ~q1_m;
        check("toggle_low", outs(), {q1_m, ~q1_m, 2'b01});
      end
      nClk1 = 1'b1;
      for (int c = 0; c < 10; c++) begin
        tick();
        check("toggle_high", outs(), {q1_m, ~q1_m, 2'b01});
      end
    end
    J1 = 1'b0; K1 = 1'b0;

    // 4. Channel 2 JK reset/set from a preset state
    nSd2 = 1'b0;
    tick();
    nSd2 = 1'b1;
    tick();
    check("set2", outs(), {q1_m, ~q1_m, 2'b10});
    J2 = 1'b0; K2 = 1'b1; nClk2 = 1'b0;
    tick();
    check("jk01", outs(), {q1_m, ~q1_m, 2'b01});
    nClk2 = 1'b1;
    tick();
    J2 = 1'b1; K2 = 1'b0;
    tick();
    check("jk10_pre", outs(), {q1_m, ~q1_m, 2'b01});
    nClk2 = 1'b0;
    tick();
    check("jk10", outs(), {q1_m, ~q1_m, 2'b10});
    nClk2 = 1'b1;
    tick();
    check("jk10_held", outs(), {q1_m, ~q1_m, 2'b10});

    // 5. Both-low, release, and an edge discarded under clear
    nSd1 = 1'b0; nRd1 = 1'b0;
    tick();
    check("both_low", outs(), 4'b1110);
    nSd1 = 1'b1; nRd1 = 1'b1;
    tick();
    check("both_release", outs(), 4'b1010);
    J1 = 1'b1; K1 = 1'b0; nRd1 = 1'b0; nClk1 = 1'b0;
    tick();
    check("edge_under_clr", outs(), 4'b0110);
    nRd1 = 1'b1;
    tick();
    check("edge_not_deferred", outs(), 4'b0110);
    nClk1 = 1'b1;
    tick();
    check("rise_no_action", outs(), 4'b0110);

    // 6. Reset coinciding with an edge and active set
    J1 = 1'b1; K1 = 1'b1;
    tick();
    nClk1 = 1'b0; nSd1 = 1'b0; rst = 1'b1;
    tick();
    check("rst_priority", outs(), 4'b0101);
    rst = 1'b0; nSd1 = 1'b1;
    tick();
    check("post_rst_low", outs(), 4'b0101);
    tick();
    check("post_rst_low2", outs(), 4'b0101);
    // Device clock high during reset, low right after: the reset edge register hides it
    nClk1 = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; nClk1 = 1'b0;
    tick();
    check("no_edge_after_rst", outs(), 4'b0101);
    nClk1 = 1'b1;
    tick();
    nClk1 = 1'b0;
    tick();
    check("toggle_after_rst", outs(), 4'b1001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lzx_74hc112_dual_jk.md
Name: lzx_74hc112_dual_jk

Overview:
Dual, fully independent JK flip-flop modelled on the 74HC112, re-timed onto a single system clock. Each channel has an active-low set input, an active-low clear input, a negative-edge "device clock" input, and J/K inputs. It drives complementary outputs Q/nQ. Used as a drop-in logic-gate library cell in the gate-level EDA test designs.

Parameters:
None.

Ports:
clk    input  1  system clock; all state updates on its rising edge
rst    input  1  synchronous, active-high reset
nSd1   input  1  channel 1 set, active low, level-sensitive
nRd1   input  1  channel 1 clear, active low, level-sensitive
nClk1  input  1  channel 1 device clock; the JK action fires on its falling edge
J1     input  1  channel 1 J
K1     input  1  channel 1 K
Q1     output 1  channel 1 Q (registered)
nQ1    output 1  channel 1 nQ (registered)
nSd2, nRd2, nClk2, J2, K2, Q2, nQ2: same as channel 1, for channel 2

Behaviour:
- One clock (clk), synchronous active-high reset (rst). All inputs are synchronous to clk; the block contains no metastability synchronizers.
- Both channels are identical and independent; the description below uses channel n.
- Edge detect:
  - Register pn holds nClkn from the previous clk cycle.
  - fall_n = pn & ~nClkn in the current cycle.
  - pn is updated every cycle, including cycles where set or clear is active.
- Reset (rst=1 at a clk edge):
  - Qn←0, nQn←1, pn←0.
  - rst has priority over every other input.
  - Because pn resets to 0, no edge can be detected in the first cycle after reset.
- Priority per cycle when rst=0, highest first:
  1. nSdn=0 and nRdn=0: Qn←1, nQn←1 (74HC112 both-low state).
  2. nSdn=0: Qn←1, nQn←0.
  3. nRdn=0: Qn←0, nQn←1.
  4. fall_n=1, JK table, where Qnew is the next Qn and nQn←~Qnew:
     - J=0, K=0: hold
     - J=0, K=1: Qnew=0
     - J=1, K=0: Qnew=1
     - J=1, K=1: Qnew=~Qn
  5. Otherwise: Qn holds; nQn←~Qn.
- A device-clock falling edge that coincides with active set or clear is discarded. It is not deferred.
- Release from the both-low state: the next cycle gives Qn=1, nQn=0 (via rule 5). A toggle applied after that uses Qn=1.
- Latency:
  - Set/clear: outputs change at the first clk edge where the input is sampled low (1 cycle).
  - JK action: takes effect at the clk edge where nClkn is first sampled low after having been sampled high.
- Outside the both-low state, nQn == ~Qn at all times.
- The channels share only clk and rst.

Test Plan:
1. Reset: assert rst for 2 cycles with all other inputs at idle values → Q1=Q2=0, nQ1=nQ2=1, and they stay so with J=K=0 while nClk toggles.
2. Set/clear: pulse nSd1=0 for 1 cycle → Q1=1, nQ1=0 one cycle later, held afterwards. Then pulse nRd1=0 → Q1=0, nQ1=1. Channel 2 outputs remain Q2=0, nQ2=1 throughout.
3. Toggle: J1=K1=1 with nClk1 toggling every 10 clk cycles → Q1 inverts exactly once per nClk1 falling edge, never on rising edges, and nQ1=~Q1 always.
4. Channel 2, J2=0, K2=1 from Q2=1 (previously set) → Q2=0 after the next nClk2 falling edge. Then J2=1, K2=0 → Q2=1 after the following falling edge. Channel 1 is unaffected.
5. Both low: nSd1=nRd1=0 → Q1=1, nQ1=1. Release both → next cycle Q1=1, nQ1=0. A falling nClk1 edge occurring while nRd1=0 with J1=1, K1=0 → Q1 stays 0.
6. Reset mid-operation: assert rst in the same cycle as a detected falling edge with J=K=1 and nSd=0 → Q=0, nQ=1. Hold nClk low during deassertion → no toggle occurs in the first post-reset cycle.
